// File: rtl/des_dec_key_sched_pkg.sv
// Shared DES key-schedule definitions: FIPS 46-3 permutation tables, shift
// schedules for both directions, and the basic key/half/subkey types.
package des_dec_key_sched_pkg;

    typedef logic [63:0] des_key_t;
    typedef logic [27:0] des_half_t;
    typedef logic [47:0] des_subkey_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    // Tables use FIPS 1-based numbering, bit 1 = MSB.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_ENC [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Entry 0 unused: PC1(key) already equals C16/D16 since 16 rounds rotate by 28.
    localparam logic [1:0] SHIFT_DEC [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic des_half_t rotr(input des_half_t x, input logic [1:0] s);
        case (s)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_dec_key_sched_if.sv
// Key/start request side and subkey valid/ready stream of the decrypt key scheduler.
interface des_dec_key_sched_if;
    import des_dec_key_sched_pkg::*;

    des_key_t    key;
    logic        start;
    logic        busy;
    des_subkey_t subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        done;

    modport master (
        output key, start, subkey_ready,
        input  busy, subkey, subkey_valid, round_idx, done
    );

    modport slave (
        input  key, start, subkey_ready,
        output busy, subkey, subkey_valid, round_idx, done
    );

endinterface

// File: rtl/des_dec_key_sched_pc2.sv
// DES PC-2: combinational 56->48 selection of the C/D state into a round subkey.
module des_pc2
    import des_dec_key_sched_pkg::*;
(
    input  logic [55:0] cd_i,
    output des_subkey_t subkey_o
);

    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
        assign subkey_o[47-gi] = cd_i[56-PC2_TAB[gi]];
    end

endmodule

// File: rtl/des_dec_key_sched.sv
// Iterative DES decrypt key schedule: loads PC1(key) once, then walks C/D with
// right rotations so that K16..K1 come out one per valid/ready handshake.
module des_dec_key_sched
    import des_dec_key_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    des_dec_key_sched_if.slave bus
);

    sched_state_t state_q;
    des_half_t    c_q, d_q;
    des_half_t    c_d, d_d;
    logic [3:0]   round_q;
    logic         busy_q, valid_q, done_q;
    logic [55:0]  pc1_w;
    logic [1:0]   shift_w;
    logic         hs_w;
    des_subkey_t  subkey_w;
    logic         parity_unused_w;

    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
        assign pc1_w[55-gi] = bus.key[64-PC1_TAB[gi]];
    end

    assign parity_unused_w = ^{bus.key[56], bus.key[48], bus.key[40], bus.key[32],
                               bus.key[24], bus.key[16], bus.key[8],  bus.key[0]};

    // Shift amount for the subkey that follows the one currently presented.
    assign shift_w = SHIFT_DEC[round_q + 4'd1];
    assign c_d     = rotr(c_q, shift_w);
    assign d_d     = rotr(d_q, shift_w);
    assign hs_w    = valid_q & bus.subkey_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        c_q     <= pc1_w[55:28];
                        d_q     <= pc1_w[27:0];
                        round_q <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (hs_w) begin
                        if (round_q == 4'd15) begin
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            c_q     <= c_d;
                            d_q     <= d_d;
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    des_pc2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (subkey_w)
    );

    assign bus.subkey       = subkey_w;
    assign bus.busy         = busy_q;
    assign bus.subkey_valid = valid_q;
    assign bus.round_idx    = round_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Bench for des_dec_key_sched: an encrypt-order FIPS key schedule model, reversed,
// supplies every expected subkey; scenarios cover stalls, ignored starts and resets.
module tb_des_dec_key_sched;

    localparam logic [63:0] KEY0   = 64'h133457799BBCDFF1;
    localparam logic [47:0] K16_0  = 48'hCB3D8B0E17F5;
    localparam logic [47:0] K1_0   = 48'h1B02EFFC7072;

    localparam int T_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int T_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int T_LS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic clk = 1'b0;
    logic rst;
    int   n_cmp, n_err;
    logic [47:0] exp_q  [16];
    logic [47:0] base_q [16];

    always #5 clk = ~clk;

    des_dec_key_sched_if bus ();

    des_dec_key_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Textbook key schedule: K1..K16 via left shifts, stored in decryption order.
    task automatic build_ref(input logic [63:0] k);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] ks;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-T_PC1[i]];
            d[27-i] = k[64-T_PC1[28+i]];
        end
        for (int r = 0; r < 16; r++) begin
            c  = (c << T_LS[r]) | (c >> (28 - T_LS[r]));
            d  = (d << T_LS[r]) | (d >> (28 - T_LS[r]));
            cd = {c, d};
            for (int j = 0; j < 48; j++) ks[47-j] = cd[56-T_PC2[j]];
            exp_q[15-r] = ks;
        end
    endtask

    task automatic start_sched(input logic [63:0] k);
        bus.key   = k;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.key   = {$urandom, $urandom};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.subkey_valid, bus.done, bus.round_idx, bus.subkey} !== 55'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b valid=%b done=%b idx=%0d subkey=%h, want all 0",
                     bus.busy, bus.subkey_valid, bus.done, bus.round_idx, bus.subkey);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.subkey_valid, bus.done} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b done=%b, want 000",
                     bus.busy, bus.subkey_valid, bus.done);
        end
    endtask

    task automatic test_ordered;
        build_ref(KEY0);
        base_q = exp_q;
        bus.subkey_ready = 1'b1;
        start_sched(KEY0);
        for (int r = 0; r < 16; r++) begin
            n_cmp++;
            if ({bus.busy, bus.subkey_valid, bus.round_idx, bus.subkey} !== {2'b11, 4'(r), exp_q[r]}) begin
                n_err++;
                $display("FAIL ordered_r%0d: got busy=%b valid=%b idx=%0d subkey=%h, want 1 1 %0d %h",
                         r, bus.busy, bus.subkey_valid, bus.round_idx, bus.subkey, r, exp_q[r]);
            end
            if (r == 0 || r == 15) begin
                n_cmp++;
                if (bus.subkey !== ((r == 0) ? K16_0 : K1_0)) begin
                    n_err++;
                    $display("FAIL known_vector_r%0d: got %h want %h", r, bus.subkey,
                             (r == 0) ? K16_0 : K1_0);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({bus.done, bus.busy, bus.subkey_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL done_pulse: got done=%b busy=%b valid=%b, want 1 0 0",
                     bus.done, bus.busy, bus.subkey_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL done_width: got done=%b one cycle later, want 0", bus.done);
        end
        $display("schedule key=%h ordered complete", KEY0);
    endtask

    task automatic test_parity;
        logic [63:0] k;
        k = KEY0 ^ 64'h0100_0000_0000_0001;
        start_sched(k);
        for (int r = 0; r < 16; r++) begin
            n_cmp++;
            if ({bus.round_idx, bus.subkey} !== {4'(r), base_q[r]}) begin
                n_err++;
                $display("FAIL parity_r%0d: got idx=%0d subkey=%h, want %0d %h",
                         r, bus.round_idx, bus.subkey, r, base_q[r]);
            end
            @(negedge clk);
        end
        $display("schedule key=%h parity-flipped complete", k);
    endtask

    task automatic test_backpressure;
        start_sched(KEY0);
        for (int r = 0; r < 16; r++) begin
            n_cmp++;
            if ({bus.subkey_valid, bus.round_idx, bus.subkey} !== {1'b1, 4'(r), base_q[r]}) begin
                n_err++;
                $display("FAIL bp_r%0d: got valid=%b idx=%0d subkey=%h, want 1 %0d %h",
                         r, bus.subkey_valid, bus.round_idx, bus.subkey, r, base_q[r]);
            end
            if (r == 3) begin
                bus.subkey_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    n_cmp++;
                    if ({bus.subkey_valid, bus.round_idx, bus.subkey} !== {1'b1, 4'd3, base_q[3]}) begin
                        n_err++;
                        $display("FAIL bp_hold_%0d: got valid=%b idx=%0d subkey=%h, want 1 3 %h",
                                 s, bus.subkey_valid, bus.round_idx, bus.subkey, base_q[3]);
                    end
                end
                bus.subkey_ready = 1'b1;
            end
            @(negedge clk);
        end
        $display("schedule key=%h with 5-cycle stall complete", KEY0);
    endtask

    task automatic test_ignored_start;
        start_sched(KEY0);
        for (int r = 0; r < 16; r++) begin
            n_cmp++;
            if ({bus.busy, bus.round_idx, bus.subkey} !== {1'b1, 4'(r), base_q[r]}) begin
                n_err++;
                $display("FAIL ign_start_r%0d: got busy=%b idx=%0d subkey=%h, want 1 %0d %h",
                         r, bus.busy, bus.round_idx, bus.subkey, r, base_q[r]);
            end
            if (r == 7) begin
                bus.start = 1'b1;
                bus.key   = ~KEY0;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL ign_start_done: got done=%b want 1", bus.done);
        end
        @(negedge clk);
        $display("schedule key=%h with ignored start complete", KEY0);
    endtask

    task automatic test_reset_mid;
        start_sched(KEY0);
        for (int r = 0; r < 10; r++) begin
            n_cmp++;
            if (bus.subkey !== base_q[r]) begin
                n_err++;
                $display("FAIL rstmid_pre_r%0d: got %h want %h", r, bus.subkey, base_q[r]);
            end
            if (r < 9) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.subkey_valid, bus.done, bus.round_idx, bus.subkey} !== 55'd0) begin
            n_err++;
            $display("FAIL rstmid_async: got busy=%b valid=%b done=%b idx=%0d subkey=%h, want all 0",
                     bus.busy, bus.subkey_valid, bus.done, bus.round_idx, bus.subkey);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_sched(KEY0);
        for (int r = 0; r < 16; r++) begin
            n_cmp++;
            if ({bus.round_idx, bus.subkey} !== {4'(r), base_q[r]}) begin
                n_err++;
                $display("FAIL rstmid_restart_r%0d: got idx=%0d subkey=%h, want %0d %h",
                         r, bus.round_idx, bus.subkey, r, base_q[r]);
            end
            @(negedge clk);
        end
        $display("schedule key=%h restarted after reset complete", KEY0);
    endtask

    task automatic test_back_to_back;
        logic [63:0] k;
        k = {$urandom, $urandom};
        build_ref(k);
        start_sched(k);
        for (int s = 0; s < 4; s++) begin
            for (int r = 0; r < 16; r++) begin
                n_cmp++;
                if ({bus.busy, bus.subkey_valid, bus.round_idx, bus.subkey} !== {2'b11, 4'(r), exp_q[r]}) begin
                    n_err++;
                    $display("FAIL b2b_s%0d_r%0d: got busy=%b valid=%b idx=%0d subkey=%h, want 1 1 %0d %h",
                             s, r, bus.busy, bus.subkey_valid, bus.round_idx, bus.subkey, r, exp_q[r]);
                end
                @(negedge clk);
            end
            n_cmp++;
            if ({bus.done, bus.busy} !== 2'b10) begin
                n_err++;
                $display("FAIL b2b_done_s%0d: got done=%b busy=%b, want 1 0", s, bus.done, bus.busy);
            end
            $display("schedule key=%h back-to-back #%0d complete", k, s);
            if (s < 3) begin
                k = {$urandom, $urandom};
                build_ref(k);
                start_sched(k);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random_stall;
        logic [63:0] k;
        logic        rdy;
        int          idx, cyc;
        for (int s = 0; s < 3; s++) begin
            k = {$urandom, $urandom};
            build_ref(k);
            bus.subkey_ready = 1'b1;
            start_sched(k);
            idx = 0;
            cyc = 0;
            while (idx < 16 && cyc < 200) begin
                n_cmp++;
                if ({bus.subkey_valid, bus.round_idx, bus.subkey} !== {1'b1, 4'(idx), exp_q[idx]}) begin
                    n_err++;
                    $display("FAIL rnd_s%0d_c%0d: got valid=%b idx=%0d subkey=%h, want 1 %0d %h",
                             s, cyc, bus.subkey_valid, bus.round_idx, bus.subkey, idx, exp_q[idx]);
                end
                rdy = 1'($urandom_range(0, 1));
                bus.subkey_ready = rdy;
                @(negedge clk);
                if (rdy) idx++;
                cyc++;
            end
            n_cmp++;
            if (idx < 16 || bus.done !== 1'b1) begin
                n_err++;
                $display("FAIL rnd_done_s%0d: got done=%b after %0d subkeys, want done=1 after 16",
                         s, bus.done, idx);
            end
            $display("schedule key=%h random-stall complete in %0d cycles", k, cyc);
            bus.subkey_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.key = '0;
        bus.start = 1'b0;
        bus.subkey_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_ordered;
        test_parity;
        test_backpressure;
        test_ignored_start;
        test_reset_mid;
        test_back_to_back;
        test_random_stall;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
